// File: rtl/wishbone_mv_master.sv
// wishbone_mv_master
// Wishbone classic master feeding the matrix-vector accelerator's slave port.
// Takes burst commands (start address, length, direction) on a valid/ready
// port and runs one single-beat Wishbone cycle per word, with the address
// stepping by one word per beat. Write data streams in on wr_*, read data
// streams out on rd_*. cyc stays asserted for the whole burst.
//
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort a beat as an error
// when no ack/err arrives within TIMEOUT_CYCLES cycles of stb rising.
//
// Ports
//   wb_clk_i, wb_rst_i              clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o         command handshake (ready only when idle)
//   cmd_we_i, cmd_adr_i, cmd_len_i  direction, start byte address, words-1
//   cmd_sel_i                       byte selects used on every beat
//   wr_valid_i/wr_ready_o/wr_data_i write-data stream
//   rd_valid_o/rd_ready_i/rd_data_o read-data stream
//   done_o, err_o                   end-of-burst pulse, abort flag with it
//   busy_o                          burst in progress
//   wbm_*                           Wishbone classic master signals
//
// State table
//   state   | meaning
//   IDLE    | waiting for a command, cmd_ready_o high
//   WDATA   | bus locked, waiting for the next write word
//   BUS     | stb asserted, waiting for ack/err (or timeout)
//   RHOLD   | bus locked, read word presented until accepted
//   DONE    | one-cycle end-of-burst pulse, error flag reported
module wishbone_mv_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    busy_o,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_BUS   = 3'd2,
        S_RHOLD = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic                 we_r;
    logic                 err_flag;
    logic                 timeout;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Reloaded whenever stb is low, so every beat gets a fresh window.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            tmo_cnt <= '0;
        else if (state != S_BUS)
            tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
        else if (tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - TW'(1);
    end

    assign timeout = (state == S_BUS) && (tmo_cnt == '0);
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Outputs decode the state register only; none follow inputs directly.
    always_comb begin
        state_nxt   = state;
        cmd_ready_o = 1'b0;
        wr_ready_o  = 1'b0;
        rd_valid_o  = 1'b0;
        wbm_cyc_o   = 1'b0;
        wbm_stb_o   = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        busy_o      = 1'b1;
        case (state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i)
                    state_nxt = cmd_we_i ? S_WDATA : S_BUS;
            end
            S_WDATA: begin
                wr_ready_o = 1'b1;
                wbm_cyc_o  = 1'b1;
                if (wr_valid_i)
                    state_nxt = S_BUS;
            end
            S_BUS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                // err outranks a simultaneous ack
                if (wbm_err_i || timeout)
                    state_nxt = S_DONE;
                else if (wbm_ack_i) begin
                    if (!we_r)
                        state_nxt = S_RHOLD;
                    else if (beat_cnt == '0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_WDATA;
                end
            end
            S_RHOLD: begin
                wbm_cyc_o  = 1'b1;
                rd_valid_o = 1'b1;
                if (rd_ready_i)
                    state_nxt = (beat_cnt == '0) ? S_DONE : S_BUS;
            end
            S_DONE: begin
                done_o    = 1'b1;
                err_o     = err_flag;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wbm_we_o = we_r & wbm_cyc_o;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_r      <= 1'b0;
            err_flag  <= 1'b0;
            beat_cnt  <= '0;
            wbm_adr_o <= '0;
            wbm_sel_o <= '0;
            wbm_dat_o <= '0;
            rd_data_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        we_r      <= cmd_we_i;
                        wbm_adr_o <= cmd_adr_i;
                        wbm_sel_o <= cmd_sel_i;
                        beat_cnt  <= cmd_len_i;
                        err_flag  <= 1'b0;
                    end
                end
                S_WDATA: begin
                    if (wr_valid_i)
                        wbm_dat_o <= wr_data_i;
                end
                S_BUS: begin
                    if (wbm_err_i || timeout)
                        err_flag <= 1'b1;
                    else if (wbm_ack_i) begin
                        if (!we_r)
                            rd_data_o <= wbm_dat_i;
                        else if (beat_cnt != '0) begin
                            beat_cnt  <= beat_cnt - LEN_WIDTH'(1);
                            wbm_adr_o <= wbm_adr_o + ADR_STEP;
                        end
                    end
                end
                S_RHOLD: begin
                    if (rd_ready_i && beat_cnt != '0) begin
                        beat_cnt  <= beat_cnt - LEN_WIDTH'(1);
                        wbm_adr_o <= wbm_adr_o + ADR_STEP;
                    end
                end
                S_DONE:  err_flag <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
